// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock supervision and staggered downstream reset release
module pll_reset_sequencer #(
    parameter int NUM_CHANNELS       = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 8,
    parameter int RELOCK_TIMEOUT     = 65536,
    parameter int EVT_CNT_W          = 8
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic                    sw_reset,
    output logic                    pll_rst,
    output logic [NUM_CHANNELS-1:0] rst_out_n,
    output logic                    ready,
    output logic [EVT_CNT_W-1:0]    lock_lost_cnt,
    output logic [EVT_CNT_W-1:0]    timeout_cnt
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > RELOCK_TIMEOUT) ? PLL_RST_CYCLES : RELOCK_TIMEOUT;
    localparam int MAX_CD  = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RELOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                  r_state;
    logic                    r_sync1;
    logic                    r_sync2;
    logic [CNT_W-1:0]        r_cnt;
    logic [CH_W-1:0]         r_ch;
    logic                    r_pll_rst;
    logic [NUM_CHANNELS-1:0] r_rst_out_n;
    logic                    r_ready;
    logic [EVT_CNT_W-1:0]    r_lock_lost;
    logic [EVT_CNT_W-1:0]    r_timeout;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CH_W-1:0]         w_ch_nxt;
    logic [NUM_CHANNELS-1:0] w_rel_nxt;
    logic                    w_ll_inc;
    logic                    w_to_inc;
    logic                    w_lk_s;

    assign w_lk_s        = r_sync2;
    assign pll_rst       = r_pll_rst;
    assign rst_out_n     = r_rst_out_n;
    assign ready         = r_ready;
    assign lock_lost_cnt = r_lock_lost;
    assign timeout_cnt   = r_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_ch_nxt    = r_ch;
        w_rel_nxt   = r_rst_out_n;
        w_ll_inc    = 1'b0;
        w_to_inc    = 1'b0;
        if (sw_reset) begin
            w_state_nxt = ST_PLL_RESET;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_PLL_RESET: begin
                    if (r_cnt == PR_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lk_s) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == TO_LAST) begin
                        w_state_nxt = ST_PLL_RESET;
                        w_cnt_nxt   = '0;
                        w_to_inc    = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!w_lk_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == LS_LAST) begin
                        w_state_nxt  = ST_RELEASE;
                        w_cnt_nxt    = '0;
                        w_ch_nxt     = '0;
                        w_rel_nxt    = '0;
                        w_rel_nxt[0] = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // the counter restarts per stage so it only ever spans STAGE_DELAY
                    if (!w_lk_s) begin
                        w_state_nxt = ST_PLL_RESET;
                        w_cnt_nxt   = '0;
                    end else if (r_ch == CH_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == SD_LAST) begin
                        w_cnt_nxt = '0;
                        w_ch_nxt  = r_ch + 1'b1;
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            if (i == int'(r_ch) + 1) begin
                                w_rel_nxt[i] = 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = '0;
                    if (!w_lk_s) begin
                        w_state_nxt = ST_PLL_RESET;
                        w_ll_inc    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_PLL_RESET;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
        if (w_state_nxt == ST_PLL_RESET) begin
            w_rel_nxt = '0;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= ST_PLL_RESET;
            r_cnt       <= '0;
            r_ch        <= '0;
            r_pll_rst   <= 1'b1;
            r_rst_out_n <= '0;
            r_ready     <= 1'b0;
            r_lock_lost <= '0;
            r_timeout   <= '0;
        end else begin
            r_sync1     <= pll_locked;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ch        <= w_ch_nxt;
            r_pll_rst   <= (w_state_nxt == ST_PLL_RESET);
            r_rst_out_n <= w_rel_nxt;
            r_ready     <= (w_state_nxt == ST_RUN);
            if (w_ll_inc && (r_lock_lost != '1)) begin
                r_lock_lost <= r_lock_lost + 1'b1;
            end
            if (w_to_inc && (r_timeout != '1)) begin
                r_timeout <= r_timeout + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer against a phase/time reference model
module tb_pll_reset_sequencer;

    localparam int NCH = 3;
    localparam int PRC = 4;
    localparam int LSC = 16;
    localparam int SD  = 2;
    localparam int RTO = 64;
    localparam int EW  = 4;
    localparam int OW  = 1 + NCH + 1 + 2 * EW;
    localparam int SAT = (1 << EW) - 1;

    localparam int P_PR   = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_REL  = 3;
    localparam int P_RUN  = 4;

    typedef logic [OW-1:0] obs_t;

    logic           refclk = 1'b0;
    logic           rst_n = 1'b1;
    logic           pll_locked = 1'b0;
    logic           sw_reset = 1'b0;
    logic           pll_rst;
    logic [NCH-1:0] rst_out_n;
    logic           ready;
    logic [EW-1:0]  lock_lost_cnt;
    logic [EW-1:0]  timeout_cnt;

    pll_reset_sequencer #(
        .NUM_CHANNELS      (NCH),
        .PLL_RST_CYCLES    (PRC),
        .LOCK_STABLE_CYCLES(LSC),
        .STAGE_DELAY       (SD),
        .RELOCK_TIMEOUT    (RTO),
        .EVT_CNT_W         (EW)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sw_reset     (sw_reset),
        .pll_rst      (pll_rst),
        .rst_out_n    (rst_out_n),
        .ready        (ready),
        .lock_lost_cnt(lock_lost_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    always #5 refclk = ~refclk;

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t exp_q[$];
    obs_t mon_exp;
    obs_t mon_got;

    // Reference model: phase plus cycles elapsed in it; outputs follow arithmetically from those.
    int   m_phase;
    int   m_t;
    int   m_ll;
    int   m_to;
    logic m_s1;
    logic m_s2;

    function automatic void model_reset();
        m_phase = P_PR;
        m_t     = 0;
        m_ll    = 0;
        m_to    = 0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
    endfunction

    function automatic void model_edge(input logic lk_in, input logic sw);
        logic lk;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk_in;
        if (sw) begin
            m_phase = P_PR;
            m_t     = 0;
        end else begin
            case (m_phase)
                P_PR: begin
                    m_t++;
                    if (m_t == PRC) begin m_phase = P_WAIT; m_t = 0; end
                end
                P_WAIT: begin
                    if (lk) begin
                        m_phase = P_STAB; m_t = 0;
                    end else begin
                        m_t++;
                        if (m_t == RTO) begin
                            m_phase = P_PR; m_t = 0;
                            if (m_to < SAT) m_to++;
                        end
                    end
                end
                P_STAB: begin
                    if (!lk) begin
                        m_phase = P_WAIT; m_t = 0;
                    end else begin
                        m_t++;
                        if (m_t == LSC) begin m_phase = P_REL; m_t = 0; end
                    end
                end
                P_REL: begin
                    if (!lk) begin
                        m_phase = P_PR; m_t = 0;
                    end else if (m_t == (NCH - 1) * SD) begin
                        m_phase = P_RUN; m_t = 0;
                    end else begin
                        m_t++;
                    end
                end
                default: begin
                    if (!lk) begin
                        m_phase = P_PR; m_t = 0;
                        if (m_ll < SAT) m_ll++;
                    end
                end
            endcase
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o = '0;
        o[OW-1] = (m_phase == P_PR);
        for (int k = 0; k < NCH; k++) begin
            o[2 * EW + 1 + k] = (m_phase == P_RUN) || (m_phase == P_REL && k * SD <= m_t);
        end
        o[2 * EW]        = (m_phase == P_RUN);
        o[2*EW-1:EW]     = EW'(m_ll);
        o[EW-1:0]        = EW'(m_to);
        return o;
    endfunction

    always @(posedge refclk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {pll_rst, rst_out_n, ready, lock_lost_cnt, timeout_cnt};
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_errors++;
                $display("FAIL scoreboard t=%0t got={pll_rst,rst_out_n,ready,ll,to}=%h required=%h",
                         $time, mon_got, mon_exp);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, exp);
        end
    endtask

    task automatic step(input logic lk, input logic sw);
        @(negedge refclk);
        rst_n      = 1'b1;
        pll_locked = lk;
        sw_reset   = sw;
        model_edge(lk, sw);
        exp_q.push_back(model_obs());
    endtask

    task automatic run_until(input logic lk, input int phase, input int tval,
                             input int budget, input string name);
        int n;
        n = 0;
        while (!(m_phase == phase && m_t == tval) && n < budget) begin
            step(lk, 1'b0);
            n++;
        end
        n_checks++;
        if (!(m_phase == phase && m_t == tval)) begin
            n_errors++;
            $display("FAIL %s_reach t=%0t got_cycles=%0d required_under=%0d", name, $time, n, budget);
        end
    endtask

    task automatic settle();
        @(posedge refclk);
        #2;
    endtask

    task automatic chk_outputs(input string name, input int prst, input int rout,
                               input int rdy, input int ll, input int to);
        chk({name, "_pll_rst"}, int'(pll_rst), prst);
        chk({name, "_rst_out_n"}, int'(rst_out_n), rout);
        chk({name, "_ready"}, int'(ready), rdy);
        chk({name, "_lock_lost_cnt"}, int'(lock_lost_cnt), ll);
        chk({name, "_timeout_cnt"}, int'(timeout_cnt), to);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic lvl;
        int   len;
        int   cyc;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge refclk);
        chk_outputs("reset", 1, 0, 0, 0, 0);

        // power-up: lock appears 10 cycles after reset release
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        run_until(1'b1, P_RUN, 0, 100, "powerup");
        settle();
        chk_outputs("powerup", 0, 7, 1, 0, 0);
        repeat (5) step(1'b1, 1'b0);

        // lock loss in RUN: resets reasserted on the third edge
        repeat (3) step(1'b0, 1'b0);
        settle();
        chk_outputs("lockloss", 1, 0, 0, 1, 0);
        run_until(1'b1, P_RUN, 0, 200, "replay");
        settle();
        chk_outputs("replay", 0, 7, 1, 1, 0);

        // sw_reset mid-RELEASE with bit 0 released and bit 1 not yet
        step(1'b1, 1'b1);
        run_until(1'b1, P_REL, 1, 200, "release");
        settle();
        chk("mid_release_rst_out_n", int'(rst_out_n), 1);
        step(1'b1, 1'b1);
        settle();
        chk_outputs("swreset", 1, 0, 0, 1, 0);

        // one-cycle lock glitch during the stability window
        run_until(1'b1, P_STAB, 10, 200, "stable");
        step(1'b0, 1'b0);
        run_until(1'b1, P_RUN, 0, 200, "unstable");
        settle();
        chk_outputs("unstable", 0, 7, 1, 1, 0);

        // lock never returns: timeout counter saturates
        for (int i = 0; i < 16 * (PRC + RTO) + 10; i++) step(1'b0, 1'b0);
        settle();
        chk("timeout_sat", int'(timeout_cnt), SAT);
        chk("timeout_lock_lost", int'(lock_lost_cnt), 2);

        // randomized lock behaviour with occasional software resets
        cyc = 0;
        while (cyc < 3000) begin
            lvl = 1'($urandom_range(0, 1));
            len = lvl ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                step(lvl, 1'($urandom_range(0, 99) == 0));
            end
            cyc += len;
        end

        // asynchronous reset while running
        step(1'b1, 1'b1);
        run_until(1'b1, P_RUN, 0, 200, "prerun");
        repeat (2) step(1'b1, 1'b0);
        @(posedge refclk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_outputs("async_reset", 1, 0, 0, 0, 0);
        run_until(1'b1, P_RUN, 0, 100, "post_reset");
        settle();
        chk_outputs("post_reset", 0, 7, 1, 0, 0);

        settle();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
